// File: rtl/snake_engine_if.sv
// Control, status and segment read-port bundle between the snake core and its neighbours.
// The master drives the game inputs and read index, and the slave is the engine.
interface snake_engine_if #(
  parameter int IDX_W = 5
);
  logic             tick;
  logic [1:0]       dir;
  logic             eat_evt;
  logic             pause;
  logic [IDX_W-1:0] rd_idx;
  logic [9:0]       head_x;
  logic [8:0]       head_y;
  logic [1:0]       heading;
  logic [7:0]       length;
  logic             busy;
  logic             step_done;
  logic             game_over;
  logic [9:0]       rd_x;
  logic [8:0]       rd_y;
  logic             rd_valid;

  modport master (
    output tick, dir, eat_evt, pause, rd_idx,
    input  head_x, head_y, heading, length, busy, step_done, game_over,
           rd_x, rd_y, rd_valid
  );

  modport slave (
    input  tick, dir, eat_evt, pause, rd_idx,
    output head_x, head_y, heading, length, busy, step_done, game_over,
           rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: one-cell moves per tick, growth on eat, reversal rejection,
// wall handling and a serial self-collision scan over the segment list.
module snake_engine #(
  parameter int CELL      = 10,
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int MAX_LEN   = 32,
  parameter int GROW_STEP = 1,
  parameter int WRAP      = 1,
  parameter int START_X   = 280,
  parameter int START_Y   = 240
) (
  input  logic          clk_pix,
  input  logic          reset,
  snake_engine_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W = 9;

  localparam logic [9:0] CX   = 10'(CELL);
  localparam logic [8:0] CY   = 9'(CELL);
  localparam logic [9:0] XMIN = 10'(CELL);
  localparam logic [9:0] XMAX = 10'((GRID_W - 2) * CELL);
  localparam logic [8:0] YMIN = 9'(CELL);
  localparam logic [8:0] YMAX = 9'((GRID_H - 2) * CELL);
  localparam logic [9:0] SX0  = 10'(START_X);
  localparam logic [9:0] SX1  = 10'(START_X - CELL);
  localparam logic [9:0] SX2  = 10'(START_X - 2 * CELL);
  localparam logic [8:0] SY   = 9'(START_Y);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] GROW    = LEN_W'(GROW_STEP);

  typedef enum logic [1:0] {IDLE, MOVE, CHECK, DEAD} state_t;

  state_t           state_q, state_d;
  logic [9:0]       seg_x_q [MAX_LEN];
  logic [9:0]       seg_x_d [MAX_LEN];
  logic [8:0]       seg_y_q [MAX_LEN];
  logic [8:0]       seg_y_d [MAX_LEN];
  logic [LEN_W-1:0] length_q, length_d;
  logic [1:0]       heading_q, heading_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             eat_pending_q, eat_pending_d;
  logic             step_done_q, step_done_d;
  logic             game_over_q, game_over_d;
  logic [9:0]       rd_x_q, rd_x_d;
  logic [8:0]       rd_y_q, rd_y_d;
  logic             rd_valid_q, rd_valid_d;

  logic [1:0]       next_dir;
  logic [9:0]       nx;
  logic [8:0]       ny;
  logic             wall;
  logic [LEN_W-1:0] grown;
  logic [LEN_W-1:0] len_grown;

  always_comb begin
    state_d       = state_q;
    seg_x_d       = seg_x_q;
    seg_y_d       = seg_y_q;
    length_d      = length_q;
    heading_d     = heading_q;
    k_d           = k_q;
    eat_pending_d = eat_pending_q;
    step_done_d   = 1'b0;
    game_over_d   = game_over_q;

    // A request for the exact opposite direction keeps the current heading.
    next_dir = (bus.dir == (heading_q ^ 2'd2)) ? heading_q : bus.dir;
    nx       = seg_x_q[0];
    ny       = seg_y_q[0];
    wall     = 1'b0;
    case (next_dir)
      2'd0: if (seg_y_q[0] <= YMIN) begin wall = 1'b1; ny = YMAX; end
            else ny = seg_y_q[0] - CY;
      2'd1: if (seg_x_q[0] <= XMIN) begin wall = 1'b1; nx = XMAX; end
            else nx = seg_x_q[0] - CX;
      2'd2: if (seg_y_q[0] >= YMAX) begin wall = 1'b1; ny = YMIN; end
            else ny = seg_y_q[0] + CY;
      default: if (seg_x_q[0] >= XMAX) begin wall = 1'b1; nx = XMIN; end
               else nx = seg_x_q[0] + CX;
    endcase

    grown     = length_q + GROW;
    len_grown = (grown > LEN_MAX) ? LEN_MAX : grown;

    if (bus.eat_evt && (state_q != DEAD)) eat_pending_d = 1'b1;

    case (state_q)
      IDLE: if (bus.tick && !bus.pause) state_d = MOVE;
      MOVE: begin
        if (wall && (WRAP == 0)) begin
          game_over_d = 1'b1;
          state_d     = DEAD;
        end else begin
          heading_d = next_dir;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nx;
          seg_y_d[0] = ny;
          // Stale tail entries become the newly revealed segments on growth.
          if (eat_pending_q) begin
            length_d      = len_grown;
            eat_pending_d = bus.eat_evt;
          end
          k_d     = IDX_W'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((seg_x_q[0] == seg_x_q[k_q]) && (seg_y_q[0] == seg_y_q[k_q])) begin
          game_over_d = 1'b1;
          state_d     = DEAD;
        end else if (LEN_W'(k_q) == (length_q - LEN_W'(1))) begin
          step_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: ;
    endcase

    rd_x_d     = seg_x_q[bus.rd_idx];
    rd_y_d     = seg_y_q[bus.rd_idx];
    rd_valid_d = (LEN_W'(bus.rd_idx) < length_q);
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i == 0) ? SX0 : ((i == 1) ? SX1 : SX2);
        seg_y_q[i] <= SY;
      end
      length_q      <= LEN_W'(3);
      heading_q     <= 2'd3;
      k_q           <= '0;
      eat_pending_q <= 1'b0;
      step_done_q   <= 1'b0;
      game_over_q   <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_x_q       <= seg_x_d;
      seg_y_q       <= seg_y_d;
      length_q      <= length_d;
      heading_q     <= heading_d;
      k_q           <= k_d;
      eat_pending_q <= eat_pending_d;
      step_done_q   <= step_done_d;
      game_over_q   <= game_over_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign bus.head_x    = seg_x_q[0];
  assign bus.head_y    = seg_y_q[0];
  assign bus.heading   = heading_q;
  assign bus.length    = length_q[7:0];
  assign bus.busy      = (state_q == MOVE) || (state_q == CHECK);
  assign bus.step_done = step_done_q;
  assign bus.game_over = game_over_q;
  assign bus.rd_x      = rd_x_q;
  assign bus.rd_y      = rd_y_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a wrapping 8-segment instance driven against a
// small reference model, and a walled instance checked for the game-over path.
module tb_snake_engine;

  localparam int A_MAX  = 8;
  localparam int A_GROW = 2;

  logic clk;
  logic reset;

  snake_engine_if #(.IDX_W(3)) if_a ();
  snake_engine_if #(.IDX_W(5)) if_b ();

  snake_engine #(.MAX_LEN(A_MAX), .GROW_STEP(A_GROW), .WRAP(1)) dut_a (
    .clk_pix(clk), .reset(reset), .bus(if_a)
  );
  snake_engine #(.WRAP(0), .START_X(600)) dut_b (
    .clk_pix(clk), .reset(reset), .bus(if_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] len;
    logic [1:0] hd;
    logic       dead;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  int   mx [A_MAX];
  int   my [A_MAX];
  int   mlen;
  int   mhd;
  bit   mpend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < A_MAX; i++) begin
      mx[i] = (i == 0) ? 280 : ((i == 1) ? 270 : 260);
      my[i] = 240;
    end
    mlen  = 3;
    mhd   = 3;
    mpend = 0;
  endfunction

  // Reference step: wrap at the 10..620 / 10..460 limits, shift, grow, scan for a hit.
  function automatic void modelStep(input int d);
    int   nd, nx, ny;
    bit   dead;
    exp_t e;
    nd = (d == (mhd ^ 2)) ? mhd : d;
    nx = mx[0];
    ny = my[0];
    case (nd)
      0: ny = (ny <= 10)  ? 460 : ny - 10;
      1: nx = (nx <= 10)  ? 620 : nx - 10;
      2: ny = (ny >= 460) ? 10  : ny + 10;
      default: nx = (nx >= 620) ? 10 : nx + 10;
    endcase
    for (int i = A_MAX - 1; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = nx;
    my[0] = ny;
    if (mpend) begin
      mlen  = (mlen + A_GROW > A_MAX) ? A_MAX : mlen + A_GROW;
      mpend = 0;
    end
    mhd  = nd;
    dead = 0;
    for (int k = 1; k < mlen; k++)
      if (mx[k] == nx && my[k] == ny) dead = 1;
    e.x    = 10'(nx);
    e.y    = 9'(ny);
    e.len  = 8'(mlen);
    e.hd   = 2'(nd);
    e.dead = dead;
    sbq.push_back(e);
  endfunction

  task automatic collectResult(input int spent);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (cnt < 64 && !if_a.step_done && !if_a.game_over) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("step_finished", 32'(if_a.step_done | if_a.game_over), 1);
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      checkOutput("head_x", 32'(if_a.head_x), 32'(e.x));
      checkOutput("head_y", 32'(if_a.head_y), 32'(e.y));
      checkOutput("length", 32'(if_a.length), 32'(e.len));
      checkOutput("heading", 32'(if_a.heading), 32'(e.hd));
      checkOutput("game_over", 32'(if_a.game_over), 32'(e.dead));
      if (!e.dead) begin
        checkOutput("step_latency", 32'(cnt + spent), 32'(e.len));
        @(negedge clk);
        checkOutput("step_done_pulse", 32'(if_a.step_done), 0);
      end else begin
        checkOutput("no_step_done", 32'(if_a.step_done), 0);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d);
    modelStep(int'(d));
    @(negedge clk);
    if_a.dir  = d;
    if_a.tick = 1'b1;
    @(negedge clk);
    if_a.tick = 1'b0;
    collectResult(0);
  endtask

  task automatic eatPulse();
    @(negedge clk);
    if_a.eat_evt = 1'b1;
    @(negedge clk);
    if_a.eat_evt = 1'b0;
    mpend = 1;
  endtask

  task automatic checkRead(input int idx, input int ex, input int ey, input bit ev);
    @(negedge clk);
    if_a.rd_idx = 3'(idx);
    @(negedge clk);
    checkOutput("rd_valid", 32'(if_a.rd_valid), 32'(ev));
    if (ev) begin
      checkOutput("rd_x", 32'(if_a.rd_x), 32'(ex));
      checkOutput("rd_y", 32'(if_a.rd_y), 32'(ey));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_head_x", 32'(if_a.head_x), 280);
    checkOutput("rst_head_y", 32'(if_a.head_y), 240);
    checkOutput("rst_length", 32'(if_a.length), 3);
    checkOutput("rst_heading", 32'(if_a.heading), 3);
    checkOutput("rst_busy", 32'(if_a.busy), 0);
    checkOutput("rst_step_done", 32'(if_a.step_done), 0);
    checkOutput("rst_game_over", 32'(if_a.game_over), 0);
    checkOutput("rst_b_head_x", 32'(if_b.head_x), 600);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    if_a.tick    = 1'b0;
    if_a.eat_evt = 1'b0;
    if_a.pause   = 1'b0;
    if_b.tick    = 1'b0;
    @(negedge clk);
    checkOutput("rst_rd_valid", 32'(if_a.rd_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    checkResetState();
    modelReset();
    sbq.delete();
  endtask

  task automatic tickB();
    int cnt;
    @(negedge clk);
    if_b.tick = 1'b1;
    @(negedge clk);
    if_b.tick = 1'b0;
    cnt = 0;
    while (cnt < 64 && !if_b.step_done && !if_b.game_over) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    if_a.tick    = 1'b0;
    if_a.dir     = 2'd3;
    if_a.eat_evt = 1'b0;
    if_a.pause   = 1'b0;
    if_a.rd_idx  = '0;
    if_b.tick    = 1'b0;
    if_b.dir     = 2'd3;
    if_b.eat_evt = 1'b0;
    if_b.pause   = 1'b0;
    if_b.rd_idx  = '0;
    repeat (2) @(negedge clk);

    $display("[TB] basic step and read port");
    doReset();
    applyStimulus(2'd3);
    checkRead(2, 270, 240, 1);
    checkRead(3, 0, 0, 0);

    $display("[TB] reversal rejection and turn");
    doReset();
    applyStimulus(2'd1);
    applyStimulus(2'd0);

    $display("[TB] tick while busy and tick while paused");
    modelStep(3);
    @(negedge clk);
    if_a.dir  = 2'd3;
    if_a.tick = 1'b1;
    @(negedge clk);
    if_a.tick = 1'b0;
    @(negedge clk);
    checkOutput("busy_in_check", 32'(if_a.busy), 1);
    if_a.tick = 1'b1;
    @(negedge clk);
    if_a.tick = 1'b0;
    collectResult(2);
    repeat (6) @(negedge clk);
    checkOutput("busy_tick_dropped", 32'(if_a.busy), 0);
    checkOutput("busy_tick_head", 32'(if_a.head_x), 300);
    if_a.pause = 1'b1;
    if_a.tick  = 1'b1;
    @(negedge clk);
    if_a.tick = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("pause_busy", 32'(if_a.busy), 0);
    checkOutput("pause_head", 32'(if_a.head_x), 300);
    if_a.pause = 1'b0;

    $display("[TB] growth and self collision");
    doReset();
    eatPulse();
    applyStimulus(2'd3);
    checkRead(3, 260, 240, 1);
    checkRead(4, 260, 240, 1);
    checkRead(5, 0, 0, 0);
    applyStimulus(2'd0);
    applyStimulus(2'd1);
    applyStimulus(2'd2);
    @(negedge clk);
    if_a.dir     = 2'd3;
    if_a.tick    = 1'b1;
    if_a.eat_evt = 1'b1;
    @(negedge clk);
    if_a.tick    = 1'b0;
    if_a.eat_evt = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("dead_busy", 32'(if_a.busy), 0);
    checkOutput("dead_head_x", 32'(if_a.head_x), 280);
    checkOutput("dead_head_y", 32'(if_a.head_y), 240);
    checkOutput("dead_sticky", 32'(if_a.game_over), 1);

    $display("[TB] reset in the middle of a scan");
    doReset();
    eatPulse();
    @(negedge clk);
    if_a.dir  = 2'd3;
    if_a.tick = 1'b1;
    @(negedge clk);
    if_a.tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState();
    modelReset();
    applyStimulus(2'd3);

    $display("[TB] wrap at the right wall");
    doReset();
    for (int i = 0; i < 34; i++) applyStimulus(2'd3);
    checkOutput("at_right_limit", 32'(if_a.head_x), 620);
    applyStimulus(2'd3);
    checkOutput("wrapped_x", 32'(if_a.head_x), 10);

    $display("[TB] length saturation");
    doReset();
    for (int i = 0; i < 4; i++) begin
      eatPulse();
      applyStimulus(2'd3);
    end
    checkOutput("length_saturated", 32'(if_a.length), A_MAX);

    $display("[TB] wall hit without wrap");
    doReset();
    tickB();
    checkOutput("b_head_610", 32'(if_b.head_x), 610);
    tickB();
    checkOutput("b_head_620", 32'(if_b.head_x), 620);
    checkOutput("b_alive", 32'(if_b.game_over), 0);
    tickB();
    checkOutput("b_game_over", 32'(if_b.game_over), 1);
    checkOutput("b_head_kept", 32'(if_b.head_x), 620);
    checkOutput("b_busy", 32'(if_b.busy), 0);
    tickB();
    repeat (4) @(negedge clk);
    checkOutput("b_tick_ignored", 32'(if_b.head_x), 620);
    checkOutput("b_still_over", 32'(if_b.game_over), 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
